pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers, and EX-stage forwarding selects.
- Freezes the front of the pipe while a multi-cycle multiply/divide op occupies EX; operand capture is done by the MD unit at start.
- Purely a control block: no datapath, drives `clr`/enable pins of the stage registers.

---
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage RV32I pipe: stalls, flushes, EX forwarding selects, MD-op freeze.
// Latency: all controls combinational from state/cnt/inputs; MD op holds EX for MD_LATENCY cycles.
// Backpressure: stalls IF/ID/EX during load-use and MD ops. Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic [REG_W-1:0] rs1E,
    input  logic [REG_W-1:0] rs2E,
    input  logic [REG_W-1:0] rdE,
    input  logic             LoadE,
    input  logic             MdStartE,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] rdM,
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] rdW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic             MdDone
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      StallCycles,
    output logic [31:0]      FlushEvents
`endif
);

    localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam bit MD_MULTI = (MD_LATENCY > 1);
    localparam logic [CW-1:0] CNT_INIT = MD_MULTI ? CW'(MD_LATENCY - 2) : '0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            lw_stall;

    // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             wr_m,
        input logic [REG_W-1:0] rd_m,
        input logic             wr_w,
        input logic [REG_W-1:0] rd_w
    );
        if (wr_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall = LoadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        MdBusy    = 1'b0;
        MdDone    = 1'b0;

        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_sel(rs1E, RegWriteM, rdM, RegWriteW, rdW);
            ForwardBE = fwd_sel(rs2E, RegWriteM, rdM, RegWriteW, rdW);
            case (state)
                IDLE: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else if (MdStartE) begin
                        if (MD_MULTI) begin
                            StallF    = 1'b1;
                            StallD    = 1'b1;
                            StallE    = 1'b1;
                            FlushM    = 1'b1;
                            state_nxt = RUN;
                            cnt_nxt   = CNT_INIT;
                        end else begin
                            MdDone = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // EX holds the MD op, so branch/load/start inputs are meaningless here.
                    MdBusy = 1'b1;
                    if (cnt != '0) begin
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        StallE  = 1'b1;
                        FlushM  = 1'b1;
                        cnt_nxt = cnt - CW'(1);
                    end else begin
                        MdDone    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if (StallF && (StallCycles != '1))
                StallCycles <= StallCycles + 32'd1;
            if ((FlushD || FlushE) && (FlushEvents != '1))
                FlushEvents <= FlushEvents + 32'd1;
        end
    end
`endif

endmodule
